// File: rtl/alu_unit_pkg.sv
// Shared constants for the alu_unit slice: opcode encoding and default operand width.
package alu_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

endpackage

// File: rtl/alu_unit_div.sv
// Unrolled combinational restoring divider: WIDTH subtract-and-compare stages.
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
module alu_unit_div
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c,
  output logic             div_zero_c
);

  logic [WIDTH:0] part;

  // One extra bit on the partial remainder: after the shift it can reach 2*b-1.
  always_comb begin
    part       = '0;
    quotient_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      part = {part[WIDTH-1:0], a[i]};
      if (part >= {1'b0, b}) begin
        part          = part - {1'b0, b};
        quotient_c[i] = 1'b1;
      end
    end
    remainder_c = part[WIDTH-1:0];
  end

  assign div_zero_c = (b == '0);

endmodule

// File: rtl/alu_unit.sv
// Single-cycle ALU (ADD/SUB/MUL/DIV) with one registered result and a valid flag.
// Build macro ALU_UNIT_DIV_EN enables the divider; without it opcode DIV returns zero.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [1:0]           i_control,
  output logic [2*WIDTH:0]     o_out,
  output logic                 o_valid
);

  localparam int unsigned OUT_W = 2 * WIDTH + 1;

  logic [OUT_W-1:0] result_c;

`ifdef ALU_UNIT_DIV_EN
  logic [WIDTH-1:0] quotient_c;
  logic [WIDTH-1:0] remainder_c;
  logic             div_zero_c;

  alu_unit_div #(.WIDTH(WIDTH)) u_div (
    .a           (i_a),
    .b           (i_b),
    .quotient_c  (quotient_c),
    .remainder_c (remainder_c),
    .div_zero_c  (div_zero_c)
  );
`endif

  // Operands are zero-extended to the full result width, so SUB wraps to a sign-extended value.
  always_comb begin
    result_c = '0;
    case (i_control)
      OP_ADD: result_c = OUT_W'(i_a) + OUT_W'(i_b);
      OP_SUB: result_c = OUT_W'(i_a) - OUT_W'(i_b);
      OP_MUL: result_c = OUT_W'(i_a) * OUT_W'(i_b);
`ifdef ALU_UNIT_DIV_EN
      OP_DIV: result_c = {div_zero_c, remainder_c, quotient_c};
`else
      OP_DIV: result_c = '0;
`endif
      default: result_c = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_out   <= result_c;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit: reference vectors, strided operand sweep, reset behaviour.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  ctrl;
  logic [16:0] out;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  alu_unit dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_a       (a),
    .i_b       (b),
    .i_control (ctrl),
    .o_out     (out),
    .o_valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [16:0] r;
    r = '0;
    case (op)
      2'd0: r = 17'(x) + 17'(y);
      2'd1: r = 17'(x) - 17'(y);
      2'd2: r = 17'(x) * 17'(y);
      default: begin
`ifdef ALU_UNIT_DIV_EN
        if (y == 8'd0) r = {1'b1, x, 8'hFF};
        else           r = {1'b0, 8'(x % y), 8'(x / y)};
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  // Drive at the falling edge, sample 1 time unit after the following rising edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [16:0] exp);
    @(negedge clk);
    ctrl = op; a = x; b = y;
    @(posedge clk);
    #1;
    check(tag, 32'(out), 32'(exp));
  endtask

  logic [16:0] div_a;
  logic [16:0] div_b;

  initial begin
`ifdef ALU_UNIT_DIV_EN
    div_a = 17'h0041C;
    div_b = 17'h105FF;
`else
    div_a = 17'h00000;
    div_b = 17'h00000;
`endif
    rst_n = 1'b0; a = 8'hFF; b = 8'hFF; ctrl = 2'd2;
    #2;
    check("reset_out", 32'(out), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    @(posedge clk); #1;
    check("reset_hold_out", 32'(out), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("valid_before_edge", 32'(valid), 32'h0);

    run_op("add_ff_ff", 2'd0, 8'hFF, 8'hFF, 17'h001FE);
    check("valid_after_edge", 32'(valid), 32'h1);
    run_op("add_0_0",   2'd0, 8'h00, 8'h00, 17'h00000);
    run_op("sub_0_1",   2'd1, 8'h00, 8'h01, 17'h1FFFF);
    run_op("sub_ff_0",  2'd1, 8'hFF, 8'h00, 17'h000FF);
    run_op("mul_ff_ff", 2'd2, 8'hFF, 8'hFF, 17'h0FE01);
    run_op("mul_10_10", 2'd2, 8'h10, 8'h10, 17'h00100);
    run_op("div_200_7", 2'd3, 8'd200, 8'd7, div_a);
    run_op("div_5_0",   2'd3, 8'd5, 8'd0, div_b);

    // Input changes between edges must leave the registered result alone.
    a = 8'h12; b = 8'h34; ctrl = 2'd0;
    #2;
    check("hold_between_edges", 32'(out), 32'(div_b));
    @(posedge clk); #1;
    check("add_12_34", 32'(out), 32'h00046);

    // Strided sweep over all opcodes, including 0 and 0xFF operands.
    for (int op = 0; op < 4; op++)
      for (int ai = 0; ai <= 255; ai += 15)
        for (int bi = 0; bi <= 255; bi += 15)
          run_op("sweep", 2'(op), 8'(ai), 8'(bi), model(2'(op), 8'(ai), 8'(bi)));

    // Reset asserted mid-cycle while a MUL result is registered.
    run_op("mul_pre_reset", 2'd2, 8'hFF, 8'hFF, 17'h0FE01);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    @(posedge clk); #1;
    check("midrst_edge_out", 32'(out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ctrl = 2'd0; a = 8'd3; b = 8'd4;
    #1;
    check("post_rst_valid_low", 32'(valid), 32'h0);
    @(posedge clk); #1;
    check("post_rst_valid_high", 32'(valid), 32'h1);
    check("post_rst_out", 32'(out), 32'h00007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
